// File: rtl/vga_bus_arbiter.sv
// Round-robin arbiter for the shared VGA plot path: grants one drawing client at a time,
// pulses its start, and forwards only that client's pixel stream through one register stage.
module vga_bus_arbiter #(
    parameter int              N_CLIENTS = 4,
    parameter int              TO_W      = 18,
    parameter logic [TO_W-1:0] TIMEOUT   = 18'd200000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_CLIENTS-1:0]    req,
    input  logic [N_CLIENTS-1:0]    done,
    input  logic [8*N_CLIENTS-1:0]  client_x,
    input  logic [8*N_CLIENTS-1:0]  client_y,
    input  logic [24*N_CLIENTS-1:0] client_rgb,
    input  logic [N_CLIENTS-1:0]    client_plot,
    output logic [N_CLIENTS-1:0]    start,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic [7:0]              vga_x,
    output logic [7:0]              vga_y,
    output logic [23:0]             vga_rgb,
    output logic                    vga_plot,
    output logic                    timeout_err,
    output logic [2:0]              err_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t                state_q;
    logic [2:0]            rr_ptr_q;
    logic [TO_W-1:0]       wd_q;
    logic                  done_early_q;
    logic [N_CLIENTS-1:0]  start_q;
    logic [2:0]            grant_id_q;
    logic                  busy_q;
    logic [7:0]            vga_x_q;
    logic [7:0]            vga_y_q;
    logic [23:0]           vga_rgb_q;
    logic                  vga_plot_q;
    logic                  timeout_err_q;
    logic [2:0]            err_id_q;

    logic [2:0]            win_d;
    logic [2:0]            rr_ptr_d;
    logic [2:0]            cand;
    logic                  found;

    logic [7:0]            sel_x;
    logic [7:0]            sel_y;
    logic [23:0]           sel_rgb;
    logic                  sel_plot;
    logic                  sel_done;

    function automatic logic [2:0] wrap_idx(input int v);
        return (v >= N_CLIENTS) ? 3'(v - N_CLIENTS) : 3'(v);
    endfunction

    // First requester at or above rr_ptr, wrapping; the constant double loop keeps indices static.
    always_comb begin
        win_d = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = wrap_idx(int'(rr_ptr_q) + i);
            for (int j = 0; j < N_CLIENTS; j++) begin
                if (!found && cand == 3'(j) && req[j]) begin
                    found = 1'b1;
                    win_d = cand;
                end
            end
        end
        rr_ptr_d = wrap_idx(int'(win_d) + 1);
    end

    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_rgb  = '0;
        sel_plot = 1'b0;
        sel_done = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_x    = client_x[8*i +: 8];
                sel_y    = client_y[8*i +: 8];
                sel_rgb  = client_rgb[24*i +: 24];
                sel_plot = client_plot[i];
                sel_done = done[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            wd_q          <= '0;
            done_early_q  <= 1'b0;
            start_q       <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_rgb_q     <= '0;
            vga_plot_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            if (state_q == S_START || state_q == S_BUSY) begin
                vga_x_q    <= sel_x;
                vga_y_q    <= sel_y;
                vga_rgb_q  <= sel_rgb;
                vga_plot_q <= sel_plot;
            end else begin
                vga_plot_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q    <= S_START;
                        grant_id_q <= win_d;
                        rr_ptr_q   <= rr_ptr_d;
                        start_q    <= {{(N_CLIENTS-1){1'b0}}, 1'b1} << win_d;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    state_q      <= S_BUSY;
                    start_q      <= '0;
                    wd_q         <= '0;
                    // A client may finish before its first busy cycle; remember it.
                    done_early_q <= sel_done;
                end
                S_BUSY: begin
                    if (sel_done || done_early_q) begin
                        state_q <= S_RELEASE;
                    end else if (wd_q == TIMEOUT - TO_W'(1)) begin
                        state_q       <= S_RELEASE;
                        timeout_err_q <= 1'b1;
                        err_id_q      <= grant_id_q;
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start       = start_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_rgb     = vga_rgb_q;
    assign vga_plot    = vga_plot_q;
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Bench for vga_bus_arbiter: directed scenarios plus randomized traffic against a
// grant-timeline reference model (TIMEOUT shortened to 16).
module tb_vga_bus_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    done = '0;
    logic [N-1:0]    client_plot = '0;
    logic [8*N-1:0]  client_x = '0;
    logic [8*N-1:0]  client_y = '0;
    logic [24*N-1:0] client_rgb = '0;
    logic [N-1:0]    start;
    logic [2:0]      grant_id;
    logic            busy;
    logic [7:0]      vga_x;
    logic [7:0]      vga_y;
    logic [23:0]     vga_rgb;
    logic            vga_plot;
    logic            timeout_err;
    logic [2:0]      err_id;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner, cycles since its start pulse, and release gap flag.
    int           m_rr, m_gid, m_age;
    bit           m_act, m_rel, m_early;
    logic [N-1:0] e_start;
    logic [2:0]   e_gid, e_eid;
    logic         e_busy, e_plot, e_terr;
    logic [7:0]   e_x, e_y;
    logic [23:0]  e_rgb;

    vga_bus_arbiter #(.N_CLIENTS(N), .TO_W(18), .TIMEOUT(18'd16)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .client_x(client_x), .client_y(client_y), .client_rgb(client_rgb),
        .client_plot(client_plot), .start(start), .grant_id(grant_id), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_rgb(vga_rgb), .vga_plot(vga_plot),
        .timeout_err(timeout_err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    function automatic logic [52:0] dut_vec();
        return {start, grant_id, busy, vga_x, vga_y, vga_rgb, vga_plot, timeout_err, err_id};
    endfunction

    function automatic logic [52:0] exp_vec();
        return {e_start, e_gid, e_busy, e_x, e_y, e_rgb, e_plot, e_terr, e_eid};
    endfunction

    task automatic model_reset();
        m_rr = 0; m_gid = 0; m_age = 0;
        m_act = 1'b0; m_rel = 1'b0; m_early = 1'b0;
        e_start = '0; e_gid = '0; e_eid = '0; e_busy = 1'b0; e_plot = 1'b0; e_terr = 1'b0;
        e_x = '0; e_y = '0; e_rgb = '0;
    endtask

    task automatic model_step();
        int  c;
        bit  found;
        if (resetn) begin
            if (m_act && !m_rel) begin
                e_x    = client_x[8*m_gid +: 8];
                e_y    = client_y[8*m_gid +: 8];
                e_rgb  = client_rgb[24*m_gid +: 24];
                e_plot = client_plot[m_gid];
            end else begin
                e_plot = 1'b0;
            end
            e_start = '0;
            if (m_rel) begin
                m_rel = 1'b0; m_act = 1'b0; e_busy = 1'b0;
            end else if (m_act) begin
                if (m_age == 0) begin
                    m_early = done[m_gid];
                    m_age = 1;
                end else if (done[m_gid] || m_early) begin
                    m_rel = 1'b1;
                end else if (m_age == T) begin
                    m_rel = 1'b1; e_terr = 1'b1; e_eid = 3'(m_gid);
                end else begin
                    m_age++;
                end
            end else if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && req[c]) begin found = 1'b1; m_gid = c; end
                end
                m_rr = (m_gid + 1) % N;
                m_act = 1'b1; m_age = 0; m_early = 1'b0;
                e_start[m_gid] = 1'b1; e_gid = 3'(m_gid); e_busy = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_pix(input int c, input logic [7:0] x, input logic [7:0] y,
                           input logic [23:0] rgb, input logic p);
        client_x[8*c +: 8]     = x;
        client_y[8*c +: 8]     = y;
        client_rgb[24*c +: 24] = rgb;
        client_plot[c]         = p;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        model_reset();
        tick();
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = '0; done = '0; client_plot = '0;
        model_reset();
        repeat (3) tick();
        n_vec++;
        if (dut_vec() !== 53'd0) begin
            n_err++; $display("FAIL reset_values: got %h, required %h", dut_vec(), 53'd0);
        end
        #2 resetn = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_idle: got %h, required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int ph = -1;
        int starts = 0;
        int pix = 0;
        int busy_fall = -1;
        req = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            if (ph >= 1 && ph <= 10) set_pix(0, 8'h12, 8'h34, 24'hFF0000, 1'b1);
            else client_plot[0] = 1'b0;
            done[0] = (ph == 11);
            if (ph == 12) req[0] = 1'b0;
            tick();
            if (e_start[0]) ph = 0; else if (ph >= 0) ph++;
            if (start[0]) starts++;
            if (vga_plot && vga_x == 8'h12 && vga_y == 8'h34 && vga_rgb == 24'hFF0000) pix++;
            if (ph > 0 && busy_fall < 0 && !busy) busy_fall = ph;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL single_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done[0] = 1'b0;
        n_vec++;
        if (starts !== 1) begin n_err++; $display("FAIL single_start_len: got %0d, required 1", starts); end
        n_vec++;
        if (pix !== 10) begin n_err++; $display("FAIL single_pixels: got %0d, required 10", pix); end
        n_vec++;
        if (busy_fall !== 13) begin n_err++; $display("FAIL single_busy_fall: got %0d, required 13", busy_fall); end
    endtask

    task automatic test_round_robin();
        int ph[N];
        int order[$];
        int exp_o[5] = '{0, 1, 2, 3, 0};
        for (int c = 0; c < N; c++) ph[c] = -1;
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < N; c++) done[c] = (ph[c] == 5);
            tick();
            for (int c = 0; c < N; c++) begin
                if (e_start[c]) ph[c] = 0;
                else if (ph[c] >= 0) ph[c] = (ph[c] >= 5) ? -1 : ph[c] + 1;
            end
            if (start != '0) order.push_back(int'(grant_id));
            if (order.size() >= 5) req = '0;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL rr_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done = '0;
        n_vec++;
        if (order.size() < 5) begin
            n_err++; $display("FAIL rr_grant_count: got %0d, required at least 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (order[i] !== exp_o[i]) begin
                    n_err++; $display("FAIL rr_order[%0d]: got %0d, required %0d", i, order[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_isolation();
        int ph = -1;
        req = 4'b0010;
        for (int k = 0; k < 30; k++) begin
            if (ph >= 1 && ph <= 8) set_pix(1, 8'h05, 8'h06, 24'h0000FF, 1'b1);
            else client_plot[1] = 1'b0;
            set_pix(2, 8'hAA, 8'hBB, 24'h00FF00, 1'b1);
            done[2] = (ph == 3);
            done[1] = (ph == 9);
            if (ph == 10) req[1] = 1'b0;
            tick();
            if (e_start[1]) ph = 0; else if (ph >= 0) ph++;
            n_vec++;
            if (vga_rgb === 24'h00FF00) begin
                n_err++; $display("FAIL iso_leak cycle %0d: got rgb %h, required not 00ff00", k, vga_rgb);
            end
            if (ph >= 4 && ph <= 8) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL iso_spurious_done ph %0d: got busy %b, required 1", ph, busy);
                end
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL iso_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done = '0;
        set_pix(2, 8'h00, 8'h00, 24'h000000, 1'b0);
    endtask

    task automatic test_collision();
        int ph = -1;
        req = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            done[0] = (ph == T);
            if (ph == T + 1) req[0] = 1'b0;
            tick();
            if (e_start[0]) ph = 0; else if (ph >= 0) ph++;
            if (ph == T + 1) begin
                n_vec++;
                if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                    n_err++; $display("FAIL collision_release: got busy %b err %b, required busy 1 err 0", busy, timeout_err);
                end
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL collision_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done = '0;
        n_vec++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL collision_final: got err %b busy %b, required 0 0", timeout_err, busy);
        end
    endtask

    task automatic test_watchdog();
        int ph3 = -1;
        int ph0 = -1;
        bit got0 = 1'b0;
        req = 4'b1000;
        for (int k = 0; k < 50; k++) begin
            done[0] = (ph0 == 2);
            if (ph3 >= T + 1 && !got0) req = 4'b1001;
            tick();
            if (e_start[3]) ph3 = 0; else if (ph3 >= 0) ph3++;
            if (e_start[0]) begin
                ph0 = 0; got0 = 1'b1; req = '0;
                n_vec++;
                if (start !== 4'b0001 || grant_id !== 3'd0) begin
                    n_err++; $display("FAIL wd_next_grant: got start %b id %0d, required 0001 0", start, grant_id);
                end
            end else if (ph0 >= 0) ph0++;
            if (ph3 == T) begin
                n_vec++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL wd_early: got err %b busy %b, required 0 1", timeout_err, busy);
                end
            end
            if (ph3 == T + 1) begin
                n_vec++;
                if (timeout_err !== 1'b1 || err_id !== 3'd3 || busy !== 1'b1) begin
                    n_err++; $display("FAIL wd_fire: got err %b id %0d busy %b, required 1 3 1", timeout_err, err_id, busy);
                end
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL wd_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done = '0;
        n_vec++;
        if (!got0) begin n_err++; $display("FAIL wd_regrant: got no grant to client 0, required one"); end
    endtask

    task automatic test_reset_mid();
        int  ph = -1;
        bit  got = 1'b0;
        req = 4'b0100;
        for (int k = 0; k < 20 && ph != 3; k++) begin
            set_pix(2, 8'h21, 8'h43, 24'h123456, ph >= 1);
            tick();
            if (e_start[2]) ph = 0; else if (ph >= 0) ph++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL mid_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (busy !== 1'b1 || vga_plot !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: got busy %b plot %b, required 1 1", busy, vga_plot);
        end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({vga_plot, start, busy, timeout_err, grant_id} !== 10'd0) begin
            n_err++; $display("FAIL mid_async: got plot %b start %b busy %b err %b id %0d, required all 0", vga_plot, start, busy, timeout_err, grant_id);
        end
        repeat (2) tick();
        client_plot = '0;
        req = 4'b1100;
        #2 resetn = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (e_start != '0) begin
                got = 1'b1;
                n_vec++;
                if (start !== 4'b0100 || grant_id !== 3'd2) begin
                    n_err++; $display("FAIL mid_rr_restart: got start %b id %0d, required 0100 2", start, grant_id);
                end
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL mid_after_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
        done[2] = 1'b1;
        req = '0;
        tick();
        done = '0;
        repeat (4) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL mid_drain: got %h, required %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int ph[N];
        int len[N];
        for (int c = 0; c < N; c++) begin ph[c] = -1; len[c] = 0; end
        for (int k = 0; k < 600; k++) begin
            client_x    = $urandom;
            client_y    = $urandom;
            client_rgb  = {$urandom, $urandom, $urandom};
            client_plot = 4'($urandom);
            done = '0;
            for (int c = 0; c < N; c++) begin
                if (!req[c] && $urandom_range(0, 5) == 0) req[c] = 1'b1;
                if (ph[c] >= 0 && ph[c] == len[c]) begin done[c] = 1'b1; req[c] = 1'b0; end
            end
            if ($urandom_range(0, 15) == 0) done[$urandom_range(0, N-1)] = 1'b1;
            tick();
            for (int c = 0; c < N; c++) begin
                if (e_start[c]) begin ph[c] = 0; len[c] = $urandom_range(0, 20); end
                else if (ph[c] >= 0) ph[c] = (ph[c] > 40) ? -1 : ph[c] + 1;
            end
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle %0d: got %h, required %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_isolation();
        test_collision();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
